// File: rtl/milley_output_monitor.sv
// Observer for the 2-bit Mealy automaton output stream. Detects a latched 4-symbol
// sequence with overlap, counts matches and accepted symbols, and locks after a
// configurable number of matches since leaving IDLE.
module milley_output_monitor #(
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned LOCK_MATCHES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [7:0]           pattern,
    input  logic                 b_valid,
    input  logic [1:0]           b,
    output logic                 match,
    output logic                 locked,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [CNT_WIDTH-1:0] symbol_count
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLocked  = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
    localparam logic [CNT_WIDTH-1:0] LockVal = CNT_WIDTH'(LOCK_MATCHES);

    state_e               state_q, state_d;
    logic [7:0]           hist_q, hist_d;
    logic [2:0]           fill_q, fill_d;
    logic [7:0]           pat_q, pat_d;
    logic                 match_q, match_d;
    logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
    // Matches since leaving IDLE; never exceeds LockVal, so it cannot saturate early
    logic [CNT_WIDTH-1:0] total_q, total_d;

    // Next-state: clear > disable > normal operation
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        match_d = 1'b0;
        mcnt_d  = mcnt_q;
        scnt_d  = scnt_q;
        total_d = total_q;

        if (clear) begin
            state_d = StIdle;
            hist_d  = '0;
            fill_d  = '0;
            mcnt_d  = '0;
            scnt_d  = '0;
            total_d = '0;
        end else if (!enable) begin
            state_d = StIdle;
            hist_d  = '0;
            fill_d  = '0;
            total_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pat_d   = pattern;
                    state_d = StAcquire;
                end
                StAcquire, StTrack: begin
                    if (b_valid) begin
                        hist_d = {b, hist_q[7:2]};
                        scnt_d = scnt_q + CNT_WIDTH'(1);
                        if (fill_q != 3'd4) begin
                            fill_d = fill_q + 3'd1;
                        end
                        if (fill_d == 3'd4) begin
                            state_d = StTrack;
                            if (hist_d == pat_q) begin
                                match_d = 1'b1;
                                if (mcnt_q != CntMax) begin
                                    mcnt_d = mcnt_q + CNT_WIDTH'(1);
                                end
                                total_d = total_q + CNT_WIDTH'(1);
                                if (total_d == LockVal) begin
                                    state_d = StLocked;
                                end
                            end
                        end
                    end
                end
                StLocked: begin
                    // Frozen until clear or disable
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            match_q <= 1'b0;
            mcnt_q  <= '0;
            scnt_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            match_q <= match_d;
            mcnt_q  <= mcnt_d;
            scnt_q  <= scnt_d;
            total_q <= total_d;
        end
    end

    assign match        = match_q;
    assign locked       = (state_q == StLocked);
    assign state        = state_q;
    assign match_count  = mcnt_q;
    assign symbol_count = scnt_q;

endmodule

// File: tb/tb_milley_output_monitor.sv
// Self-checking bench: two monitors (8-bit and 2-bit counters) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_milley_output_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       b_valid = 1'b0;
    logic [1:0] b = 2'd0;

    logic       match8, locked8, match2, locked2;
    logic [1:0] state8, state2;
    logic [7:0] mcnt8, scnt8;
    logic [1:0] mcnt2, scnt2;

    int tests = 0;
    int fails = 0;

    // Reference model: accepted symbols since leaving IDLE, unbounded counts
    int         m_state;
    int         m_syms[$];
    int         m_mc, m_sc, m_total;
    bit         m_match;
    logic [7:0] m_pat;

    always #5 clk = ~clk;

    milley_output_monitor #(.CNT_WIDTH(8), .LOCK_MATCHES(3)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pattern(pattern),
        .b_valid(b_valid), .b(b), .match(match8), .locked(locked8), .state(state8),
        .match_count(mcnt8), .symbol_count(scnt8)
    );

    milley_output_monitor #(.CNT_WIDTH(2), .LOCK_MATCHES(3)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pattern(pattern),
        .b_valid(b_valid), .b(b), .match(match2), .locked(locked2), .state(state2),
        .match_count(mcnt2), .symbol_count(scnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_syms.delete();
        m_mc = 0;
        m_sc = 0;
        m_total = 0;
        m_match = 1'b0;
        m_pat = 8'h00;
    endtask

    task automatic model_step(input logic en, input logic clr, input logic [7:0] pat,
                              input logic bv, input logic [1:0] bb);
        bit hit;
        m_match = 1'b0;
        if (clr) begin
            m_state = 0;
            m_syms.delete();
            m_mc = 0;
            m_sc = 0;
            m_total = 0;
        end else if (!en) begin
            m_state = 0;
            m_syms.delete();
            m_total = 0;
        end else if (m_state == 0) begin
            m_pat = pat;
            m_state = 1;
        end else if (m_state != 3 && bv) begin
            m_syms.push_back(int'(bb));
            if (m_syms.size() > 4) void'(m_syms.pop_front());
            m_sc++;
            if (m_syms.size() == 4) begin
                m_state = 2;
                hit = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_syms[i] != int'(m_pat[2*i +: 2])) hit = 1'b0;
                if (hit) begin
                    m_match = 1'b1;
                    m_mc++;
                    m_total++;
                    if (m_total == 3) m_state = 3;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("state8", state8, m_state);
        chk("state2", state2, m_state);
        chk("match8", match8, m_match);
        chk("match2", match2, m_match);
        chk("locked8", locked8, (m_state == 3));
        chk("locked2", locked2, (m_state == 3));
        chk("mcnt8", mcnt8, (m_mc > 255) ? 255 : m_mc);
        chk("mcnt2", mcnt2, (m_mc > 3) ? 3 : m_mc);
        chk("scnt8", scnt8, m_sc % 256);
        chk("scnt2", scnt2, m_sc % 4);
    endtask

    // Drive inputs just after an edge, advance one edge, check 1 time unit later
    task automatic cycle(input logic en, input logic clr, input logic [7:0] pat,
                         input logic bv, input logic [1:0] bb);
        enable = en;
        clear = clr;
        pattern = pat;
        b_valid = bv;
        b = bb;
        model_step(en, clr, pat, bv, bb);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic restart(input logic [7:0] pat);
        cycle(1'b1, 1'b1, pat, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, pat, 1'b0, 2'd0);
    endtask

    logic [7:0] rpat;
    logic [1:0] rb;

    initial begin
        model_reset();
        #1;
        check_all();
        #11;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Ordered stream 0,1,2,3 against pattern 11_10_01_00
        restart(8'b11_10_01_00);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));
        cycle(1'b1, 1'b0, 8'hE4, 1'b0, 2'd0);

        // Overlapping 01 run, lock at the third match, 7th symbol ignored
        restart(8'h55);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 2'd1);

        // Disable leaves LOCKED; counters held
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 2'd1);

        // Gapped valid qualifier
        restart(8'hE4);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'hE4, (i % 2) == 0, 2'(i / 2));

        // Long zero run: 2-bit counters saturate / wrap
        restart(8'h00);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 2'd0);

        // Clear on the completing symbol, then re-acquire
        restart(8'hE4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));
        cycle(1'b1, 1'b1, 8'hE4, 1'b1, 2'd3);
        cycle(1'b1, 1'b0, 8'hE4, 1'b0, 2'd0);

        // Disable on the completing symbol
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));
        cycle(1'b0, 1'b0, 8'hE4, 1'b1, 2'd3);

        // Asynchronous reset between edges mid-acquire
        cycle(1'b1, 1'b0, 8'hE4, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'hE4, 1'b0, 2'd0);
        for (int i = 2; i < 4; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hE4, 1'b1, 2'(i));

        // Randomised traffic with binary-symbol patterns for frequent matches
        for (int n = 0; n < 600; n++) begin
            rpat = 8'($urandom);
            if ($urandom_range(0, 9) != 0)
                for (int i = 0; i < 4; i++) rpat[2*i +: 2] = 2'($urandom_range(0, 1));
            rb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                             : 2'($urandom_range(0, 1));
            cycle($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 2, rpat,
                  $urandom_range(0, 3) != 0, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
